// File: rtl/btn_debounce_if.sv
// Button conditioner signal bundle: raw pin in, clean level and event strobes out.
// The master side drives the pin; the slave side is the debouncer.
interface btn_debounce_if;
  logic       btn_in;
  logic       btn_level;
  logic       press_pulse;
  logic       release_pulse;
  logic       long_pulse;
  logic [7:0] press_count;

  modport master (
    output btn_in,
    input  btn_level, press_pulse, release_pulse, long_pulse, press_count
  );

  modport slave (
    input  btn_in,
    output btn_level, press_pulse, release_pulse, long_pulse, press_count
  );
endinterface

// File: rtl/btn_debounce.sv
// Push-button conditioner: 2-flop synchroniser, two-edge debounce FSM, registered
// level, press/release/long-press strobes and a wrapping 8-bit press counter.
module btn_debounce #(
  parameter bit ACTIVE_LOW      = 1'b1,
  parameter int DEBOUNCE_CYCLES = 270000,
  parameter int LONG_CYCLES     = 27000000
) (
  input  logic           clk_in,
  input  logic           rst,
  btn_debounce_if.slave  bus
);

  localparam int DBW = $clog2(DEBOUNCE_CYCLES);
  localparam int HW  = $clog2(LONG_CYCLES + 1);
  localparam logic [DBW-1:0] DB_LAST   = DBW'(DEBOUNCE_CYCLES - 1);
  localparam logic [HW-1:0]  HOLD_LAST = HW'(LONG_CYCLES - 1);
  localparam logic [DBW-1:0] DB_ONE    = DBW'(1);
  localparam logic [HW-1:0]  HOLD_ONE  = HW'(1);

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    DB_PRESS = 3'd1,
    HELD     = 3'd2,
    LONG     = 3'd3,
    DB_REL   = 3'd4
  } state_t;

  state_t         state_reg, state_next;
  logic [1:0]     sync_reg;
  logic [DBW-1:0] db_cnt_reg, db_cnt_next;
  logic [HW-1:0]  hold_cnt_reg, hold_cnt_next;
  logic           long_done_reg, long_done_next;
  logic           level_reg, level_next;
  logic           press_reg, press_next;
  logic           release_reg, release_next;
  logic           long_reg, long_next;
  logic [7:0]     count_reg, count_next;
  logic           pressed;

  // Synchroniser resets to the released pin level so reset release never looks like a press.
  always_ff @(posedge clk_in or posedge rst) begin
    if (rst) begin
      sync_reg <= {2{ACTIVE_LOW}};
    end else begin
      sync_reg <= {sync_reg[0], bus.btn_in};
    end
  end

  assign pressed = sync_reg[1] ^ ACTIVE_LOW;

  always_ff @(posedge clk_in or posedge rst) begin
    if (rst) begin
      state_reg     <= IDLE;
      db_cnt_reg    <= '0;
      hold_cnt_reg  <= '0;
      long_done_reg <= 1'b0;
      level_reg     <= 1'b0;
      press_reg     <= 1'b0;
      release_reg   <= 1'b0;
      long_reg      <= 1'b0;
      count_reg     <= '0;
    end else begin
      state_reg     <= state_next;
      db_cnt_reg    <= db_cnt_next;
      hold_cnt_reg  <= hold_cnt_next;
      long_done_reg <= long_done_next;
      level_reg     <= level_next;
      press_reg     <= press_next;
      release_reg   <= release_next;
      long_reg      <= long_next;
      count_reg     <= count_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE: begin
        if (pressed) state_next = DB_PRESS;
      end
      DB_PRESS: begin
        if (!pressed) state_next = IDLE;
        else if (db_cnt_reg == DB_LAST) state_next = HELD;
      end
      HELD: begin
        if (!pressed) state_next = DB_REL;
        else if (hold_cnt_reg == HOLD_LAST) state_next = LONG;
      end
      LONG: begin
        if (!pressed) state_next = DB_REL;
      end
      DB_REL: begin
        if (pressed) state_next = long_done_reg ? LONG : HELD;
        else if (db_cnt_reg == DB_LAST) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    db_cnt_next    = db_cnt_reg;
    hold_cnt_next  = hold_cnt_reg;
    long_done_next = long_done_reg;
    level_next     = level_reg;
    press_next     = 1'b0;
    release_next   = 1'b0;
    long_next      = 1'b0;
    count_next     = count_reg;
    case (state_reg)
      IDLE: begin
        level_next = 1'b0;
        if (pressed) db_cnt_next = DB_ONE;
      end
      DB_PRESS: begin
        if (pressed) begin
          if (db_cnt_reg == DB_LAST) begin
            press_next     = 1'b1;
            level_next     = 1'b1;
            count_next     = count_reg + 8'd1;
            hold_cnt_next  = '0;
            long_done_next = 1'b0;
          end else begin
            db_cnt_next = db_cnt_reg + DB_ONE;
          end
        end
      end
      HELD: begin
        if (!pressed) begin
          db_cnt_next = DB_ONE;
        end else begin
          hold_cnt_next = hold_cnt_reg + HOLD_ONE;
          if (hold_cnt_reg == HOLD_LAST) begin
            long_next      = 1'b1;
            long_done_next = 1'b1;
          end
        end
      end
      LONG: begin
        if (!pressed) db_cnt_next = DB_ONE;
      end
      DB_REL: begin
        // hold_cnt is deliberately left untouched so a release glitch does not restart the long timer.
        if (!pressed) begin
          if (db_cnt_reg == DB_LAST) begin
            release_next = 1'b1;
            level_next   = 1'b0;
          end else begin
            db_cnt_next = db_cnt_reg + DB_ONE;
          end
        end
      end
      default: begin
        level_next     = 1'b0;
        db_cnt_next    = '0;
        hold_cnt_next  = '0;
        long_done_next = 1'b0;
      end
    endcase
  end

  assign bus.btn_level     = level_reg;
  assign bus.press_pulse   = press_reg;
  assign bus.release_pulse = release_reg;
  assign bus.long_pulse    = long_reg;
  assign bus.press_count   = count_reg;

endmodule

// File: tb/tb_btn_debounce.sv
// Directed bench for btn_debounce with short debounce/long windows; pulse timing is
// measured in clock cycles from the negedge on which btn_in was changed.
module tb_btn_debounce;

  localparam int DB   = 4;
  localparam int LONG = 20;

  logic clk_in = 1'b0;
  logic rst;
  btn_debounce_if bus();

  btn_debounce #(
    .ACTIVE_LOW      (1'b1),
    .DEBOUNCE_CYCLES (DB),
    .LONG_CYCLES     (LONG)
  ) dut (
    .clk_in (clk_in),
    .rst    (rst),
    .bus    (bus)
  );

  always #5 clk_in = ~clk_in;

  int cyc = 0;
  always @(posedge clk_in) cyc <= cyc + 1;

  int n_checks = 0;
  int n_pass   = 0;
  int n_press = 0, n_rel = 0, n_long = 0;
  int last_press = -1, last_rel = -1, last_long = -1;

  task automatic check(input string tag, input int got, input int exp);
    n_checks++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  // Event monitor: records when each strobe is seen, and that strobes never overlap.
  always @(negedge clk_in) begin
    if (!rst) begin
      if (bus.press_pulse)   begin n_press++; last_press = cyc; end
      if (bus.release_pulse) begin n_rel++;   last_rel   = cyc; end
      if (bus.long_pulse)    begin n_long++;  last_long  = cyc; end
      if (bus.press_pulse || bus.release_pulse || bus.long_pulse)
        check("one_strobe", int'(bus.press_pulse) + int'(bus.release_pulse) + int'(bus.long_pulse), 1);
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL timeout: got no finish expected finish by 2000000ns");
    $fatal(1, "bench timeout");
  end

  task automatic wait_cyc(input int n);
    repeat (n) @(negedge clk_in);
  endtask

  int p, r, q, p0, r0, l0;

  initial begin
    rst = 1'b1;
    bus.btn_in = 1'b1;
    wait_cyc(3);
    check("rst_level", bus.btn_level, 0);
    check("rst_count", bus.press_count, 0);
    check("rst_pulses", int'(bus.press_pulse) + int'(bus.release_pulse) + int'(bus.long_pulse), 0);
    rst = 1'b0;
    wait_cyc(10);
    check("no_pulse_after_rst", n_press + n_rel + n_long, 0);

    // 1: clean press held 30 cycles, then release
    p0 = n_press; r0 = n_rel; l0 = n_long;
    bus.btn_in = 1'b0; p = cyc;
    wait_cyc(30);
    check("t1_press_lat", last_press - p, 6);
    check("t1_press_n", n_press - p0, 1);
    check("t1_level", bus.btn_level, 1);
    check("t1_count", bus.press_count, 1);
    check("t1_long_n", n_long - l0, 1);
    check("t1_long_lat", last_long - last_press, LONG);
    bus.btn_in = 1'b1; r = cyc;
    wait_cyc(10);
    check("t1_rel_lat", last_rel - r, 6);
    check("t1_rel_n", n_rel - r0, 1);
    check("t1_level_off", bus.btn_level, 0);
    check("t1_long_once", n_long - l0, 1);
    $display("test1 clean press: press@+%0d long@+%0d rel@+%0d", last_press - p, last_long - last_press, last_rel - r);

    // 2: bounce every 2 cycles for 12 cycles, then settle pressed
    p0 = n_press; r0 = n_rel; l0 = n_long;
    p = cyc;
    for (int i = 0; i < 6; i++) begin
      bus.btn_in = (i % 2 == 0) ? 1'b0 : 1'b1;
      wait_cyc(2);
    end
    bus.btn_in = 1'b0;
    wait_cyc(10);
    check("t2_press_n", n_press - p0, 1);
    check("t2_press_lat", last_press - p, 18);
    check("t2_rel_n", n_rel - r0, 0);
    check("t2_count", bus.press_count, 2);
    bus.btn_in = 1'b1;
    wait_cyc(10);
    check("t2_long_n", n_long - l0, 0);
    $display("test2 bounce: press@+%0d", last_press - p);

    // 3: short press
    p0 = n_press; r0 = n_rel; l0 = n_long;
    bus.btn_in = 1'b0; p = cyc;
    wait_cyc(10);
    bus.btn_in = 1'b1; r = cyc;
    wait_cyc(10);
    check("t3_press_lat", last_press - p, 6);
    check("t3_rel_lat", last_rel - r, 6);
    check("t3_rel_n", n_rel - r0, 1);
    check("t3_long_n", n_long - l0, 0);
    check("t3_level", bus.btn_level, 0);
    check("t3_count", bus.press_count, 3);
    $display("test3 short press: press@+%0d rel@+%0d", last_press - p, last_rel - r);

    // 4: 2-cycle release glitch inside HELD; long fires 3 cycles late (frozen hold counter)
    p0 = n_press; r0 = n_rel; l0 = n_long;
    bus.btn_in = 1'b0; p = cyc;
    wait_cyc(10);
    bus.btn_in = 1'b1;
    wait_cyc(2);
    bus.btn_in = 1'b0;
    wait_cyc(6);
    check("t4_level_glitch", bus.btn_level, 1);
    wait_cyc(24);
    check("t4_rel_n", n_rel - r0, 0);
    check("t4_level", bus.btn_level, 1);
    check("t4_long_n", n_long - l0, 1);
    check("t4_long_lat", last_long - last_press, LONG + 3);
    bus.btn_in = 1'b1;
    wait_cyc(10);
    check("t4_rel_after", n_rel - r0, 1);
    check("t4_count", bus.press_count, 4);
    $display("test4 release glitch: long@+%0d after press", last_long - last_press);

    // 5: counter wrap after 256 presses from reset
    rst = 1'b1;
    wait_cyc(2);
    check("t5_rst_count", bus.press_count, 0);
    rst = 1'b0;
    wait_cyc(4);
    p0 = n_press; r0 = n_rel; l0 = n_long;
    for (int i = 0; i < 256; i++) begin
      bus.btn_in = 1'b0;
      wait_cyc(8);
      bus.btn_in = 1'b1;
      wait_cyc(8);
      if (i == 254) check("t5_count_255", bus.press_count, 255);
    end
    check("t5_count_wrap", bus.press_count, 0);
    check("t5_press_n", n_press - p0, 256);
    check("t5_rel_n", n_rel - r0, 256);
    check("t5_long_n", n_long - l0, 0);
    $display("test5 wrap: presses=%0d releases=%0d count=%0d", n_press - p0, n_rel - r0, bus.press_count);

    // 6: asynchronous reset while in LONG with the button still held
    bus.btn_in = 1'b0;
    wait_cyc(30);
    check("t6_pre_level", bus.btn_level, 1);
    @(posedge clk_in);
    #2 rst = 1'b1;
    #1;
    check("t6_async_level", bus.btn_level, 0);
    check("t6_async_count", bus.press_count, 0);
    wait_cyc(2);
    rst = 1'b0; q = cyc;
    p0 = n_press; l0 = n_long;
    wait_cyc(30);
    check("t6_press_lat", last_press - q, 6);
    check("t6_press_n", n_press - p0, 1);
    check("t6_count", bus.press_count, 1);
    check("t6_long_lat", last_long - last_press, LONG);
    bus.btn_in = 1'b1;
    wait_cyc(10);
    $display("test6 reset mid-hold: press@+%0d long@+%0d", last_press - q, last_long - last_press);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
